// File: rtl/aukv_wb_stage.sv
// Writeback stage: retires one instruction at a time into the GPR write port and counts retirements.
// Latency: ALU results 1 cycle after accept, loads 1 cycle after the data-memory response.
// Backpressure: o_ready drops for the whole time a load waits on memory; i_valid is ignored then.
module aukv_wb_stage #(
    parameter int P_TIMEOUT = 255,
    parameter int P_CNT_W   = 32
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [4:0]         i_rd_addr,
    input  logic               i_rd_we,
    input  logic               i_is_load,
    input  logic [2:0]         i_funct3,
    input  logic [1:0]         i_addr_lo,
    input  logic [31:0]        i_alu_result,
    input  logic               i_dmem_rvalid,
    input  logic [31:0]        i_dmem_rdata,
    output logic               o_we,
    output logic [4:0]         o_rd_addr,
    output logic [31:0]        o_data,
    output logic [P_CNT_W-1:0] o_instret,
    output logic               o_err
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(P_TIMEOUT - 1);

    state_t      state;
    logic [4:0]  ld_rd;
    logic        ld_we;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [15:0] tmo_cnt;
    logic [31:0] shift_b;
    logic [31:0] shift_h;
    logic [31:0] ld_data;

    assign o_ready = (state == IDLE);

    // Lane select by shifting the addressed byte/halfword down to bit 0.
    always_comb begin
        shift_b = i_dmem_rdata >> {ld_addr_lo, 3'b000};
        shift_h = i_dmem_rdata >> {ld_addr_lo[1], 4'b0000};
        case (ld_funct3)
            3'b000:  ld_data = {{24{shift_b[7]}}, shift_b[7:0]};
            3'b001:  ld_data = {{16{shift_h[15]}}, shift_h[15:0]};
            3'b100:  ld_data = {24'h000000, shift_b[7:0]};
            3'b101:  ld_data = {16'h0000, shift_h[15:0]};
            default: ld_data = i_dmem_rdata;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            ld_rd      <= 5'd0;
            ld_we      <= 1'b0;
            ld_funct3  <= 3'd0;
            ld_addr_lo <= 2'd0;
            tmo_cnt    <= 16'd0;
            o_we       <= 1'b0;
            o_rd_addr  <= 5'd0;
            o_data     <= 32'd0;
            o_instret  <= '0;
            o_err      <= 1'b0;
        end else begin
            o_we  <= 1'b0;
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    // A response with no load outstanding is dropped but still flagged.
                    if (i_dmem_rvalid) begin
                        o_err <= 1'b1;
                    end
                    if (i_valid) begin
                        if (i_is_load) begin
                            ld_rd      <= i_rd_addr;
                            ld_we      <= i_rd_we;
                            ld_funct3  <= i_funct3;
                            ld_addr_lo <= i_addr_lo;
                            tmo_cnt    <= 16'd0;
                            state      <= WAIT_MEM;
                        end else begin
                            if (i_rd_we && (i_rd_addr != 5'd0)) begin
                                o_we      <= 1'b1;
                                o_rd_addr <= i_rd_addr;
                                o_data    <= i_alu_result;
                            end
                            o_instret <= o_instret + P_CNT_W'(1);
                        end
                    end
                end
                WAIT_MEM: begin
                    if (i_dmem_rvalid) begin
                        if (ld_we && (ld_rd != 5'd0)) begin
                            o_we      <= 1'b1;
                            o_rd_addr <= ld_rd;
                            o_data    <= ld_data;
                        end
                        o_instret <= o_instret + P_CNT_W'(1);
                        state     <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_err <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aukv_wb_stage.sv
// Randomised bench for aukv_wb_stage: stimulus tasks push expected writes/errors, a negedge monitor checks them.
module tb_aukv_wb_stage;

    localparam int TMO = 8;
    localparam int CW  = 4;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [4:0]    i_rd_addr = '0;
    logic          i_rd_we = 1'b0;
    logic          i_is_load = 1'b0;
    logic [2:0]    i_funct3 = '0;
    logic [1:0]    i_addr_lo = '0;
    logic [31:0]   i_alu_result = '0;
    logic          i_dmem_rvalid = 1'b0;
    logic [31:0]   i_dmem_rdata = '0;
    logic          o_we;
    logic [4:0]    o_rd_addr;
    logic [31:0]   o_data;
    logic [CW-1:0] o_instret;
    logic          o_err;

    aukv_wb_stage #(.P_TIMEOUT(TMO), .P_CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we), .i_is_load(i_is_load),
        .i_funct3(i_funct3), .i_addr_lo(i_addr_lo), .i_alu_result(i_alu_result),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_we(o_we), .o_rd_addr(o_rd_addr), .o_data(o_data),
        .o_instret(o_instret), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    int          err_pending = 0;
    int unsigned exp_cnt = 0;
    int          n_tot = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // Reference load extraction: pick the addressed lane arithmetically, then extend.
    function automatic logic [31:0] ext(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] tb_b;
        logic [31:0] tb_h;
        int sb;
        int sh;
        tb_b = (w >> (8 * int'(lo))) & 32'h0000_00FF;
        tb_h = (w >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
        sb = (tb_b >= 128) ? int'(tb_b) - 256 : int'(tb_b);
        sh = (tb_h >= 32768) ? int'(tb_h) - 65536 : int'(tb_h);
        case (f3)
            3'b000:  return 32'(sb);
            3'b001:  return 32'(sh);
            3'b100:  return tb_b;
            3'b101:  return tb_h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] cnt_exp();
        return 32'(exp_cnt % (1 << CW));
    endfunction

    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (o_we) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {31'd0, o_we}, 32'd0);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_rd", {27'd0, o_rd_addr}, {27'd0, w.rd});
                    chk("wr_data", o_data, w.data);
                end
            end
            if (o_err) begin
                chk("err_expected", (err_pending > 0) ? 32'd1 : 32'd0, 32'd1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    task automatic alu(input logic [4:0] rd, input logic we, input logic [31:0] d);
        i_valid      = 1'b1;
        i_is_load    = 1'b0;
        i_rd_addr    = rd;
        i_rd_we      = we;
        i_alu_result = d;
        i_funct3     = 3'($urandom);
        i_addr_lo    = 2'($urandom);
        if (we && rd != 5'd0) wq.push_back('{rd: rd, data: d});
        exp_cnt++;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    // delay = cycle after accept in which rvalid is presented; 0 means never respond.
    task automatic load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                        input logic [1:0] lo, input logic [31:0] rdata, input int delay);
        int n;
        i_valid      = 1'b1;
        i_is_load    = 1'b1;
        i_rd_addr    = rd;
        i_rd_we      = we;
        i_funct3     = f3;
        i_addr_lo    = lo;
        i_alu_result = $urandom;
        @(posedge i_clk);
        #1;
        n = (delay == 0) ? TMO : delay - 1;
        if (delay == 0) err_pending++;
        for (int k = 0; k < n; k++) begin
            chk("ready_wait", {31'd0, o_ready}, 32'd0);
            i_valid   = 1'($urandom);
            i_is_load = 1'($urandom);
            i_rd_addr = 5'($urandom);
            @(posedge i_clk);
            #1;
        end
        if (delay != 0) begin
            chk("ready_wait", {31'd0, o_ready}, 32'd0);
            i_dmem_rvalid = 1'b1;
            i_dmem_rdata  = rdata;
            if (we && rd != 5'd0) wq.push_back('{rd: rd, data: ext(f3, lo, rdata)});
            exp_cnt++;
            @(posedge i_clk);
            #1;
            i_dmem_rvalid = 1'b0;
        end
        i_valid = 1'b0;
        chk("ready_after_load", {31'd0, o_ready}, 32'd1);
        chk("instret_load", {28'd0, o_instret}, cnt_exp());
    endtask

    task automatic spurious(input logic [31:0] d, input logic with_alu);
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = d;
        err_pending++;
        if (with_alu) begin
            alu(5'($urandom_range(1, 31)), 1'b1, $urandom);
        end else begin
            @(posedge i_clk);
            #1;
        end
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
        chk({tag, "_we"}, {31'd0, o_we}, 32'd0);
        chk({tag, "_rd"}, {27'd0, o_rd_addr}, 32'd0);
        chk({tag, "_data"}, o_data, 32'd0);
        chk({tag, "_instret"}, {28'd0, o_instret}, 32'd0);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge i_clk);
        i_rstn  = 1'b1;
        exp_cnt = 0;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("reset");
        release_reset();
        check_reset_outputs("post_reset");

        alu(5'd5, 1'b1, 32'h1234_5678);
        alu(5'd0, 1'b1, 32'hFFFF_FFFF);
        @(posedge i_clk);
        #1;
        chk("instret_two", {28'd0, o_instret}, 32'd2);

        load(5'd7, 1'b1, 3'b000, 2'd3, 32'h80FF_0011, 4);
        load(5'd8, 1'b1, 3'b101, 2'd2, 32'hBEEF_1234, 2);
        load(5'd9, 1'b1, 3'b001, 2'd2, 32'hBEEF_1234, 1);
        load(5'd10, 1'b1, 3'b100, 2'd1, 32'h0000_A500, 3);
        load(5'd11, 1'b1, 3'b000, 2'd0, 32'h1111_1111, TMO);
        load(5'd12, 1'b1, 3'b010, 2'd1, 32'h2222_2222, 0);
        alu(5'd13, 1'b1, 32'hCAFE_0001);
        spurious(32'hDEAD_BEEF, 1'b0);
        spurious(32'h0BAD_F00D, 1'b1);
        @(posedge i_clk);
        #1;
        chk("instret_directed", {28'd0, o_instret}, cnt_exp());

        // Reset in the middle of an outstanding load, then a late response.
        i_valid = 1'b1; i_is_load = 1'b1; i_rd_addr = 5'd3; i_rd_we = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        release_reset();
        check_reset_outputs("midload_release");
        spurious(32'hDEAD_BEEF, 1'b0);

        for (int i = 0; i < 17; i++) alu(5'($urandom), 1'($urandom), $urandom);
        chk("instret_wrap", {28'd0, o_instret}, 32'd1);

        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 5))
                0, 1: alu(5'($urandom), 1'($urandom), $urandom);
                2, 3: load(5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                           int'($urandom_range(1, TMO)));
                4:    load(5'($urandom), 1'($urandom), 3'($urandom), 2'($urandom), $urandom, 0);
                default: spurious($urandom, 1'($urandom));
            endcase
        end

        repeat (3) @(posedge i_clk);
        #1;
        chk("final_instret", {28'd0, o_instret}, cnt_exp());
        chk("writes_drained", 32'(wq.size()), 32'd0);
        chk("errors_drained", 32'(err_pending), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
